state_app_multi: RTL and testbench



---
 rtl/state_app_multi.sv | 204 ++++++++++++++++++++
 tb/tb_state_app_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/state_app_multi.sv
// Front-panel mode controller: IDLE -> LED sweep -> MOTOR stepping/counting -> HOLD.
// Inputs are synchronised internally, and every output comes from a register or a direct decode of one.
module state_app_multi #(
    parameter int LED_CH     = 4,
    parameter int LED_CNT_W  = 8,
    parameter int NUM_DIGITS = 4,
    parameter int STEP_DIV   = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  dir,
    input  logic                  motor_sense,
    output logic [LED_CH-1:0]     fled_r,
    output logic [LED_CH-1:0]     fled_g,
    output logic [LED_CH-1:0]     fled_b,
    output logic [3:0]            step_motor,
    output logic [7:0]            seg_dat,
    output logic [NUM_DIGITS-1:0] seg_com
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LED   = 2'd1;
    localparam logic [1:0] S_MOTOR = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic r_mode_s1, r_mode_s2, r_mode_d, r_mode_pulse;
    logic r_sense_s1, r_sense_s2, r_sense_d, r_sense_pulse;
    logic r_dir_s1, r_dir_s2;
    logic [1:0] r_state;
    logic [LED_CNT_W-1:0] r_cnt_fled;
    logic [STEP_W-1:0] r_presc;
    logic [1:0] r_phase;
    logic [3:0] r_step_motor;
    logic [3:0] w_phase_pat;
    logic [3:0] r_bcd [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_carry;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DIG_W-1:0] r_scan_dig;
    logic [NUM_DIGITS-1:0] w_com_sel;
    logic [3:0] w_digit;
    logic [7:0] r_seg_dat;
    logic [NUM_DIGITS-1:0] r_seg_com;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0: s = 8'hFC;
            4'd1: s = 8'h60;
            4'd2: s = 8'hDA;
            4'd3: s = 8'hF2;
            4'd4: s = 8'h66;
            4'd5: s = 8'hB6;
            4'd6: s = 8'hBE;
            4'd7: s = 8'hE0;
            4'd8: s = 8'hFE;
            4'd9: s = 8'hE6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Edge pulses are registered so the state/count update lands three edges after sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_s1     <= 1'b0;
            r_mode_s2     <= 1'b0;
            r_mode_d      <= 1'b0;
            r_mode_pulse  <= 1'b0;
            r_sense_s1    <= 1'b0;
            r_sense_s2    <= 1'b0;
            r_sense_d     <= 1'b0;
            r_sense_pulse <= 1'b0;
            r_dir_s1      <= 1'b0;
            r_dir_s2      <= 1'b0;
        end else begin
            r_mode_s1     <= mode;
            r_mode_s2     <= r_mode_s1;
            r_mode_d      <= r_mode_s2;
            r_mode_pulse  <= r_mode_s2 & ~r_mode_d;
            r_sense_s1    <= motor_sense;
            r_sense_s2    <= r_sense_s1;
            r_sense_d     <= r_sense_s2;
            r_sense_pulse <= r_sense_s2 & ~r_sense_d;
            r_dir_s1      <= dir;
            r_dir_s2      <= r_dir_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (r_mode_pulse) begin
            r_state <= r_state + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != S_LED) begin
            r_cnt_fled <= '0;
        end else begin
            r_cnt_fled <= r_cnt_fled + LED_CNT_W'(1);
        end
    end

    assign fled_r = {LED_CH{r_cnt_fled[LED_CNT_W-1]}};
    assign fled_g = {LED_CH{r_cnt_fled[LED_CNT_W-2]}};
    assign fled_b = {LED_CH{r_cnt_fled[LED_CNT_W-3]}};

    always_ff @(posedge clk) begin
        if (rst || r_state != S_MOTOR) begin
            r_presc <= '0;
            r_phase <= 2'd0;
        end else if (r_presc == STEP_LAST) begin
            r_presc <= '0;
            r_phase <= r_dir_s2 ? r_phase + 2'd1 : r_phase - 2'd1;
        end else begin
            r_presc <= r_presc + STEP_W'(1);
        end
    end

    always_comb begin
        w_phase_pat = 4'b1100;
        case (r_phase)
            2'd0: w_phase_pat = 4'b1100;
            2'd1: w_phase_pat = 4'b0110;
            2'd2: w_phase_pat = 4'b0011;
            2'd3: w_phase_pat = 4'b1001;
            default: w_phase_pat = 4'b1100;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != S_MOTOR) begin
            r_step_motor <= 4'b0000;
        end else begin
            r_step_motor <= w_phase_pat;
        end
    end

    assign step_motor = r_step_motor;

    // Ripple carry: a digit advances only when every lower digit is 9.
    assign w_carry[0] = r_sense_pulse;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_carry
            assign w_carry[gi] = w_carry[gi-1] & (r_bcd[gi-1] == 4'd9);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || r_state == S_LED) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_bcd[i] <= 4'd0;
            end
        end else if (r_state == S_MOTOR) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_carry[i]) begin
                    r_bcd[i] <= (r_bcd[i] == 4'd9) ? 4'd0 : r_bcd[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_scan_dig <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan_dig <= (r_scan_dig == DIG_LAST) ? '0 : r_scan_dig + DIG_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_com
            assign w_com_sel[gi] = (r_scan_dig == DIG_W'(gi));
        end
    endgenerate

    assign w_digit = r_bcd[r_scan_dig];

    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || r_state == S_LED) begin
            r_seg_dat <= 8'h00;
            r_seg_com <= '1;
        end else begin
            r_seg_dat <= seg_encode(w_digit);
            r_seg_com <= ~w_com_sel;
        end
    end

    assign seg_dat = r_seg_dat;
    assign seg_com = r_seg_com;
endmodule

// File: tb/tb_state_app_multi.sv
// Bench for state_app_multi: directed phases plus random inputs, every cycle compared
// against a behavioural model built from input histories and per-mode counters.
module tb_state_app_multi;
    localparam int LED_CH    = 4;
    localparam int LED_CNT_W = 8;
    localparam int ND        = 2;
    localparam int SD        = 4;
    localparam int SCD       = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic dir = 1'b0;
    logic motor_sense = 1'b0;
    logic [LED_CH-1:0] fled_r, fled_g, fled_b;
    logic [3:0] step_motor;
    logic [7:0] seg_dat;
    logic [ND-1:0] seg_com;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    state_app_multi #(
        .LED_CH(LED_CH), .LED_CNT_W(LED_CNT_W), .NUM_DIGITS(ND),
        .STEP_DIV(SD), .SCAN_DIV(SCD)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .dir(dir), .motor_sense(motor_sense),
        .fled_r(fled_r), .fled_g(fled_g), .fled_b(fled_b),
        .step_motor(step_motor), .seg_dat(seg_dat), .seg_com(seg_com)
    );

    // Model: 0 IDLE, 1 LED, 2 MOTOR, 3 HOLD
    logic [7:0] SEG [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};
    logic [3:0] PAT [4]  = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    int m_state, m_count, m_phase, m_cyc, m_t;
    logic [7:0] m_led;
    logic [4:0] mh, sh;
    logic [2:0] dh;
    logic [3:0] e_step;
    logic [7:0] e_seg;
    logic [ND-1:0] e_com;
    logic [7:0] got1, got0;
    int mode_hold, sense_hold;

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp_v, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        int dig;
        @(posedge clk);
        if (rst) begin
            mh = '0; sh = '0; dh = '0;
            m_state = 0; m_count = 0; m_phase = 0; m_cyc = 0; m_t = 0; m_led = 8'd0;
            e_step = 4'b0000; e_seg = 8'h00; e_com = '1;
        end else begin
            mh = {mh[3:0], mode};
            sh = {sh[3:0], motor_sense};
            dh = {dh[1:0], dir};
            dig = (m_t / SCD) % ND;
            e_step = (m_state == 2) ? PAT[m_phase] : 4'b0000;
            if (m_state >= 2) begin
                e_seg = SEG[(m_count / pow10(dig)) % 10];
                e_com = ~(ND'(1) << dig);
            end else begin
                e_seg = 8'h00;
                e_com = '1;
            end
            m_led = (m_state == 1) ? m_led + 8'd1 : 8'd0;
            if (m_state == 2) begin
                m_cyc++;
                if (m_cyc % SD == 0) m_phase = dh[2] ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
            end else begin
                m_cyc = 0;
                m_phase = 0;
            end
            if (m_state == 2 && sh[3] && !sh[4]) m_count = (m_count + 1) % pow10(ND);
            else if (m_state < 2) m_count = 0;
            if (mh[3] && !mh[4]) m_state = (m_state + 1) % 4;
            m_t++;
        end
        #1;
        chk("fled_r", 8'(fled_r), 8'({LED_CH{m_led[7]}}));
        chk("fled_g", 8'(fled_g), 8'({LED_CH{m_led[6]}}));
        chk("fled_b", 8'(fled_b), 8'({LED_CH{m_led[5]}}));
        chk("step_motor", 8'(step_motor), 8'(e_step));
        chk("seg_dat", seg_dat, e_seg);
        chk("seg_com", 8'(seg_com), 8'(e_com));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        mode = 1'b1; ticks(3);
        mode = 1'b0; ticks(3);
    endtask

    task automatic pulse_sense();
        motor_sense = 1'b1; ticks(2);
        motor_sense = 1'b0; ticks(2);
    endtask

    task automatic check_display(input string tag, input logic [7:0] exp1, input logic [7:0] exp0);
        got1 = 8'hxx;
        got0 = 8'hxx;
        for (int i = 0; i < 2 * ND * SCD + 2; i++) begin
            tick();
            if (seg_com === 2'b01) got1 = seg_dat;
            if (seg_com === 2'b10) got0 = seg_dat;
        end
        chk({tag, "_d1"}, got1, exp1);
        chk({tag, "_d0"}, got0, exp0);
    endtask

    initial begin
        rst = 1'b1; ticks(3);
        rst = 1'b0; ticks(2);

        press();                 // -> LED
        ticks(260);
        press();                 // -> MOTOR
        dir = 1'b1; ticks(24);
        dir = 1'b0; ticks(24);
        dir = 1'b1;
        repeat (100) pulse_sense();
        check_display("wrap00", 8'hFC, 8'hFC);
        repeat (37) pulse_sense();
        check_display("cnt37", 8'hF2, 8'hE0);
        press();                 // -> HOLD
        repeat (5) pulse_sense();
        check_display("hold37", 8'hF2, 8'hE0);
        press();                 // -> IDLE
        chk("idle_blank_dat", seg_dat, 8'h00);
        chk("idle_blank_com", 8'(seg_com), 8'(2'b11));

        mode_hold = 0;
        sense_hold = 0;
        for (int i = 0; i < 1500; i++) begin
            mode_hold++;
            sense_hold++;
            if (mode_hold >= 2 && $urandom_range(0, 39) == 0) begin
                mode = ~mode;
                mode_hold = 0;
            end
            if (sense_hold >= 2 && $urandom_range(0, 3) == 0) begin
                motor_sense = ~motor_sense;
                sense_hold = 0;
            end
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            tick();
        end

        // Reset while in MOTOR with count 42 and coils at 0011
        rst = 1'b1; mode = 1'b0; motor_sense = 1'b0; ticks(2);
        rst = 1'b0; ticks(2);
        dir = 1'b1;
        press(); press();
        repeat (42) pulse_sense();
        check_display("cnt42", 8'h66, 8'hDA);
        for (int i = 0; i < 40 && step_motor !== 4'b0011; i++) tick();
        chk("wait_0011", 8'(step_motor), 8'(4'b0011));
        rst = 1'b1; mode = 1'b1;
        tick();
        chk("rst_step", 8'(step_motor), 8'h00);
        chk("rst_seg_dat", seg_dat, 8'h00);
        chk("rst_seg_com", 8'(seg_com), 8'(2'b11));
        chk("rst_fled_r", 8'(fled_r), 8'h00);
        mode = 1'b0;
        tick();
        rst = 1'b0;
        ticks(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
